rf_batch_sequencer: RTL and testbench



---
 rtl/rf_batch_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_rf_batch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_batch_sequencer.sv
// -----------------------------------------------------------------------------
// rf_batch_sequencer
//
// Autonomous batch controller for the LFSR / mux / register-file / ALU
// datapath. It drives the same control signals as the manual button FSM, and a
// select outside this block decides which controller owns the datapath.
//
// Two job kinds:
//   FILL    : write `count` consecutive registers starting at dst_base with
//             LFSR values (one element per cycle).
//   COMPUTE : rd[dst+i] = ALU(op_cfg, rs1[src1+i], rs2[src2+i]) for
//             i = 0..count-1, processed in ascending order. Each element takes
//             a read cycle followed by a write cycle.
// All address arithmetic wraps modulo 2**ADDR_W.
//
// Handshake: `start` is only looked at in IDLE. The job configuration is
// captured on that edge, so later input changes do not disturb a running job.
// `busy` is high from LATCH through FIN. `done` pulses for one cycle in FIN. An
// `abort` in LATCH/FILL_WR/CMP_RD/CMP_WR returns to IDLE without a `done`
// pulse. A write presented in the abort cycle still lands. If start and
// abort are both high in IDLE, start wins.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, abort      job request / job cancel
//   mode              0 = FILL, 1 = COMPUTE
//   op_cfg            ALU code for COMPUTE
//   src1_base, src2_base, dst_base, count   job geometry
//   busy, done        job status
//   we, mux, op       register-file write enable, data_in select, ALU code
//   addr              write address
//   addr_rs1/rs2      read addresses
//   idx               elements completed in the current/last job
//   dbg_state         current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module rf_batch_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [OP_W-1:0]   op_cfg,
  input  logic [ADDR_W-1:0] src1_base,
  input  logic [ADDR_W-1:0] src2_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic              mux,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_rs1,
  output logic [ADDR_W-1:0] addr_rs2,
  output logic [CNT_W-1:0]  idx,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_FILL_WR = 3'd2,
    S_CMP_RD  = 3'd3,
    S_CMP_WR  = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t            state_q, state_d;

  // Latched job configuration
  logic              mode_q, mode_d;
  logic [OP_W-1:0]   op_cfg_q, op_cfg_d;
  logic [ADDR_W-1:0] src1_q, src1_d;
  logic [ADDR_W-1:0] src2_q, src2_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered outputs
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              mux_q, mux_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  // Element bookkeeping. Offsets are truncated to ADDR_W so that block
  // addresses wrap around the register file, including when count exceeds
  // the file depth.
  logic [CNT_W-1:0]  idx_inc;
  logic              last_elem;
  logic [ADDR_W-1:0] off_cur;
  logic [ADDR_W-1:0] off_nxt;

  assign idx_inc   = idx_q + CNT_W'(1);
  assign last_elem = (idx_inc == count_q);
  assign off_cur   = idx_q[ADDR_W-1:0];
  assign off_nxt   = idx_inc[ADDR_W-1:0];

  // The next-state logic also computes every output's next value, so all
  // outputs come straight from flops and describe the state being entered.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    op_cfg_d = op_cfg_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    mux_d    = mux_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    idx_d    = idx_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = S_LATCH;
          busy_d   = 1'b1;
          mode_d   = mode;
          op_cfg_d = op_cfg;
          src1_d   = src1_base;
          src2_d   = src2_base;
          dst_d    = dst_base;
          count_d  = count;
          idx_d    = '0;
          op_d     = '0;
        end
      end

      S_LATCH: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (count_q == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (!mode_q) begin
          state_d = S_FILL_WR;
          we_d    = 1'b1;
          mux_d   = 1'b0;
          addr_d  = dst_q;
        end else begin
          state_d = S_CMP_RD;
          mux_d   = 1'b1;
          op_d    = op_cfg_q;
          rs1_d   = src1_q;
          rs2_d   = src2_q;
        end
      end

      S_FILL_WR: begin
        // The write presented this cycle lands on this edge regardless of
        // abort, so the element counts as completed.
        idx_d = idx_inc;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (last_elem) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = dst_q + off_nxt;
        end
      end

      S_CMP_RD: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_CMP_WR;
          we_d    = 1'b1;
          addr_d  = dst_q + off_cur;
        end
      end

      S_CMP_WR: begin
        idx_d = idx_inc;
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (last_elem) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_CMP_RD;
          rs1_d   = src1_q + off_nxt;
          rs2_d   = src2_q + off_nxt;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      op_cfg_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      mux_q    <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      op_cfg_q <= op_cfg_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dst_q    <= dst_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      mux_q    <= mux_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      idx_q    <= idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign we        = we_q;
  assign mux       = mux_q;
  assign op        = op_q;
  assign addr      = addr_q;
  assign addr_rs1  = rs1_q;
  assign addr_rs2  = rs2_q;
  assign idx       = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_batch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rf_batch_sequencer
//
// Directed bench for rf_batch_sequencer. It surrounds the DUT with a small
// datapath model: an 8-bit LFSR, a 32-entry register file and an ALU
// (op 1 = add, op 2 = sub). A negedge monitor pops an expected write-address
// queue for every we cycle, and per-cycle checks cover the control outputs.
// -----------------------------------------------------------------------------
module tb_rf_batch_sequencer;
  localparam int AW = 5;
  localparam int OW = 4;
  localparam int CW = 6;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT ----------------
  logic          start, abort, mode;
  logic [OW-1:0] op_cfg;
  logic [AW-1:0] src1_base, src2_base, dst_base;
  logic [CW-1:0] count;
  logic          busy, done, we, mux;
  logic [OW-1:0] op;
  logic [AW-1:0] addr, addr_rs1, addr_rs2;
  logic [CW-1:0] idx;
  logic [2:0]    dbg_state;

  rf_batch_sequencer #(.ADDR_W(AW), .OP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .op_cfg(op_cfg), .src1_base(src1_base), .src2_base(src2_base),
    .dst_base(dst_base), .count(count), .busy(busy), .done(done), .we(we),
    .mux(mux), .op(op), .addr(addr), .addr_rs1(addr_rs1),
    .addr_rs2(addr_rs2), .idx(idx), .dbg_state(dbg_state)
  );

  // ---------------- datapath model ----------------
  logic [DW-1:0] rf [32] = '{default: '0};
  logic [DW-1:0] lfsr = 8'h01;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] alu_a, alu_b, alu_y;

  assign alu_a = rf[addr_rs1];
  assign alu_b = rf[addr_rs2];
  always_comb begin
    alu_y = '0;
    case (op)
      4'd1:    alu_y = alu_a + alu_b;
      4'd2:    alu_y = alu_a - alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  always @(posedge clk) begin
    lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (pre_we)  rf[pre_addr] <= pre_data;
    else if (we) rf[addr] <= mux ? alu_y : lfsr;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (we) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else                   check("wr_addr", 32'(addr), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  // Presents a job with start high for one edge; returns in the LATCH cycle.
  task automatic launch(input logic m, input logic [OW-1:0] opc,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input logic [AW-1:0] d, input logic [CW-1:0] cnt);
    mode = m; op_cfg = opc; src1_base = s1; src2_base = s2;
    dst_base = d; count = cnt; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!done && cyc < 200);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int dc;
    logic [DW-1:0] expv [3];

    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; op_cfg = '0;
    src1_base = '0; src2_base = '0; dst_base = '0; count = '0;
    step(); step();
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_we",    32'(we), 32'd0);
    check("rst_idx",   32'(idx), 32'd0);
    rst = 1'b1;
    step();

    preload(5'd0, 8'd5);
    preload(5'd1, 8'd3);

    // Reset while in CMP_WR: asserted before the negedge, so no write is seen.
    launch(1'b1, 4'd1, 5'd0, 5'd1, 5'd20, 6'd3);
    step(); step();
    check("pre_rst_state", 32'(dbg_state), 32'd4);
    check("pre_rst_we",    32'(we), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_we",   32'(we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_outs",  {busy, done, we, mux, op, addr, addr_rs1, addr_rs2, idx}, 32'd0);
    check("post_rst_nodone", 32'(done_cnt), 32'd0);

    // FILL dst 4, count 3: writes at 4,5,6 on consecutive cycles.
    exp_q.push_back(5'd4); exp_q.push_back(5'd5); exp_q.push_back(5'd6);
    launch(1'b0, 4'd0, 5'd0, 5'd0, 5'd4, 6'd3);
    check("fill_latch_state", 32'(dbg_state), 32'd1);
    check("fill_latch_busy",  32'(busy), 32'd1);
    check("fill_latch_we",    32'(we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fill_we",   32'(we), 32'd1);
      check("fill_mux",  32'(mux), 32'd0);
      check("fill_addr", 32'(addr), 32'(4 + i));
      check("fill_idx",  32'(idx), 32'(i));
      expv[i] = lfsr;
    end
    step();
    check("fill_fin_done", 32'(done), 32'd1);
    check("fill_fin_busy", 32'(busy), 32'd1);
    check("fill_fin_we",   32'(we), 32'd0);
    step();
    check("fill_idle_busy", 32'(busy), 32'd0);
    check("fill_idle_done", 32'(done), 32'd0);
    check("fill_idx_hold",  32'(idx), 32'd3);
    for (int i = 0; i < 3; i++) check("fill_data", 32'(rf[4 + i]), 32'(expv[i]));

    // COMPUTE add: 5 + 3 -> reg 2. Start edge plus three more edges reach FIN.
    exp_q.push_back(5'd2);
    launch(1'b1, 4'd1, 5'd0, 5'd1, 5'd2, 6'd1);
    step();
    check("add_rd_state", 32'(dbg_state), 32'd3);
    check("add_rd_we",    32'(we), 32'd0);
    check("add_rd_mux",   32'(mux), 32'd1);
    check("add_rd_op",    32'(op), 32'd1);
    check("add_rd_rs1",   32'(addr_rs1), 32'd0);
    check("add_rd_rs2",   32'(addr_rs2), 32'd1);
    step();
    check("add_wr_state", 32'(dbg_state), 32'd4);
    check("add_wr_addr",  32'(addr), 32'd2);
    step();
    check("add_latency_done", 32'(done), 32'd1);
    check("add_result", 32'(rf[2]), 32'd8);
    step();

    // Wrap: dst 30, count 4 -> 30, 31, 0, 1.
    exp_q.push_back(5'd30); exp_q.push_back(5'd31);
    exp_q.push_back(5'd0);  exp_q.push_back(5'd1);
    launch(1'b0, 4'd0, 5'd0, 5'd0, 5'd30, 6'd4);
    run_to_done(cyc);
    check("wrap_cycles", 32'(cyc), 32'd5);
    check("wrap_idx", 32'(idx), 32'd4);
    check("wrap_op_zero", 32'(op), 32'd0);
    step();
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // count 0 with abort also high at start: start wins, LATCH then FIN.
    dc = done_cnt;
    abort = 1'b1;
    launch(1'b0, 4'd0, 5'd0, 5'd0, 5'd9, 6'd0);
    abort = 1'b0;
    check("cnt0_latch_state", 32'(dbg_state), 32'd1);
    run_to_done(cyc);
    check("cnt0_cycles", 32'(cyc), 32'd1);
    step();
    check("cnt0_done_count", 32'(done_cnt), 32'(dc + 1));

    // Abort in the second CMP_RD of a count-5 job; a start while busy and
    // changed inputs must not affect the running job.
    preload(5'd8, 8'd20);
    preload(5'd9, 8'd7);
    dc = done_cnt;
    exp_q.push_back(5'd16);
    launch(1'b1, 4'd2, 5'd8, 5'd9, 5'd16, 6'd5);
    step();
    start = 1'b1; mode = 1'b0; dst_base = 5'd0; count = 6'd9; op_cfg = 4'd1;
    step();
    start = 1'b0;
    check("abort_wr0_addr", 32'(addr), 32'd16);
    step();
    check("abort_rd1_state", 32'(dbg_state), 32'd3);
    check("abort_rd1_rs1",   32'(addr_rs1), 32'd9);
    check("abort_rd1_rs2",   32'(addr_rs2), 32'd10);
    check("abort_rd1_op",    32'(op), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_we",    32'(we), 32'd0);
    check("abort_idx",   32'(idx), 32'd1);
    step();
    check("abort_stay_idle", 32'(dbg_state), 32'd0);
    check("abort_no_done",   32'(done_cnt), 32'(dc));
    check("abort_result",    32'(rf[16]), 32'd13);
    check("abort_op_hold",   32'(op), 32'd2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
